// File: rtl/uart_pkg.sv
// Shared UART register map and field positions.
// Used by the RX controller here and by the TX controller. Holds the byte
// offsets of the APB registers, the register-select enum derived from
// PADDR[3:2], CTRL/STATUS bit positions, and the data-bits legal range.
package uart_pkg;

  // Byte offsets of the word-aligned APB registers.
  localparam logic [3:0] ADDR_CTRL    = 4'h0;
  localparam logic [3:0] ADDR_STATUS  = 4'h4;
  localparam logic [3:0] ADDR_DATA    = 4'h8;
  localparam logic [3:0] ADDR_TIMEOUT = 4'hC;

  // Register select, taken from PADDR[3:2].
  typedef enum logic [1:0] {
    REG_CTRL    = 2'd0,
    REG_STATUS  = 2'd1,
    REG_DATA    = 2'd2,
    REG_TIMEOUT = 2'd3
  } reg_sel_e;

  // CTRL field positions.
  localparam int CTRL_RXEN     = 0;
  localparam int CTRL_DBITS_LO = 1;
  localparam int CTRL_DBITS_HI = 4;
  localparam int CTRL_PARITY   = 5;
  localparam int CTRL_STOP2    = 6;
  localparam int CTRL_IE_RX    = 7;
  localparam int CTRL_IE_ERR   = 8;
  localparam int CTRL_FLUSH    = 9;
  localparam int CTRL_WM_LO    = 12;
  localparam int CTRL_WM_HI    = 15;

  // STATUS field positions.
  localparam int STAT_EMPTY     = 0;
  localparam int STAT_FULL      = 1;
  localparam int STAT_OVERRUN   = 2;
  localparam int STAT_FRAME_ERR = 3;
  localparam int STAT_TIMEOUT   = 4;
  localparam int STAT_LEVEL_LO  = 8;
  localparam int STAT_LEVEL_HI  = 14;

  // Legal data-bits range for a frame.
  localparam logic [3:0] DATA_BITS_MIN = 4'd5;
  localparam logic [3:0] DATA_BITS_MAX = 4'd8;

  // Force a requested data-bits value into the legal range.
  function automatic logic [3:0] clamp_data_bits(input logic [3:0] req);
    logic [3:0] res;
    res = req;
    if (req < DATA_BITS_MIN) res = DATA_BITS_MIN;
    else if (req > DATA_BITS_MAX) res = DATA_BITS_MAX;
    return res;
  endfunction

endpackage

// File: rtl/uart_rx_ctrl_if.sv
// APB slave bus bundle for the UART receive controller.
// Signals: PSEL, PENABLE, PWRITE, PADDR[3:0], PWDATA[31:0] (master -> slave);
//          PRDATA[31:0], PREADY, PSLVERR (slave -> master).
// Handshake: an access completes on the rising edge where PSEL & PENABLE are
// both high; PREADY is held at 1 so every access phase is exactly one cycle.
interface uart_rx_ctrl_if;
  logic        PSEL;
  logic        PENABLE;
  logic        PWRITE;
  logic [3:0]  PADDR;
  logic [31:0] PWDATA;
  logic [31:0] PRDATA;
  logic        PREADY;
  logic        PSLVERR;

  modport master (
    output PSEL, PENABLE, PWRITE, PADDR, PWDATA,
    input  PRDATA, PREADY, PSLVERR
  );

  modport slave (
    input  PSEL, PENABLE, PWRITE, PADDR, PWDATA,
    output PRDATA, PREADY, PSLVERR
  );
endinterface

// File: rtl/uart_rx_fifo.sv
// Synchronous receive FIFO.
// Ports: clk, rst_n (sync, active-low), push/din, pop/dout (head shown
// combinationally), flush (empties the FIFO, beats push/pop), full, empty,
// level (0..DEPTH).
// Pointers carry one extra wrap bit so full and empty are distinguishable.
// A push while full is accepted only when a pop happens in the same cycle.
module uart_rx_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic                       pop,
  input  logic                       flush,
  input  logic [WIDTH-1:0]           din,
  output logic [WIDTH-1:0]           dout,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     level
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign level   = wr_ptr - rd_ptr;
  assign dout    = mem[rd_ptr[AW-1:0]];
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage needs no reset; only the pointers define valid contents.
  always_ff @(posedge clk) begin
    if (rst_n && !flush && do_push) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/uart_rx_ctrl.sv
// APB-side receive controller for one UART instance.
// Ports: PCLK, PRESETn (sync, active-low), apb (APB slave bundle),
//   baud_tick (one strobe per bit time), rx_done/rx_data (completed
//   character), error_rx_detect (frame/parity/stop error strobe);
//   RXen, number_data_receive, parity_bit_mode, stop_bit_twice (frame format
//   to rx_fsm), data_is_avail (FIFO can take a character), irq (level irq).
// Registers: CTRL 0x0, STATUS 0x4, DATA 0x8 (read pops), TIMEOUT 0xC.
module uart_rx_ctrl
  import uart_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int TO_W  = 8
) (
  input  logic             PCLK,
  input  logic             PRESETn,
  uart_rx_ctrl_if.slave    apb,
  input  logic             baud_tick,
  input  logic             rx_done,
  input  logic [7:0]       rx_data,
  input  logic             error_rx_detect,
  output logic             RXen,
  output logic [3:0]       number_data_receive,
  output logic             parity_bit_mode,
  output logic             stop_bit_twice,
  output logic             data_is_avail,
  output logic             irq
);
  localparam int AW = $clog2(DEPTH);

  // Configuration registers.
  logic            rxen;
  logic [3:0]      data_bits;
  logic            parity;
  logic            stop2;
  logic            ie_rx;
  logic            ie_err;
  logic [3:0]      watermark;
  logic [TO_W-1:0] to_thr;

  // Sticky status and timeout state.
  logic            overrun;
  logic            frame_err;
  logic            timeout;
  logic [TO_W-1:0] to_cnt;

  // FIFO connections.
  logic [7:0]      fifo_dout;
  logic            fifo_full;
  logic            fifo_empty;
  logic [AW:0]     fifo_level;

  // APB decode.
  reg_sel_e        reg_sel;
  logic            acc;
  logic            addr_ok;
  logic            wr_en;
  logic            rd_en;
  logic            wr_ctrl;
  logic            wr_status;
  logic            wr_to;
  logic            flush;
  logic            pop;
  logic            push;
  logic            ovr_set;
  logic            to_inc;
  logic            to_set;
  logic [31:0]     rdata;
  logic            irq_next;
  logic [7:0]      level8;
  logic [3:0]      wm_eff;
  logic            unused_bits;

  assign reg_sel   = reg_sel_e'(apb.PADDR[3:2]);
  assign acc       = apb.PSEL & apb.PENABLE;
  assign addr_ok   = (apb.PADDR[1:0] == 2'b00);
  assign wr_en     = acc & apb.PWRITE & addr_ok;
  assign rd_en     = acc & ~apb.PWRITE & addr_ok;
  assign wr_ctrl   = wr_en & (reg_sel == REG_CTRL);
  assign wr_status = wr_en & (reg_sel == REG_STATUS);
  assign wr_to     = wr_en & (reg_sel == REG_TIMEOUT);
  assign flush     = wr_ctrl & apb.PWDATA[CTRL_FLUSH];
  assign pop       = rd_en & (reg_sel == REG_DATA) & ~fifo_empty;

  // A full FIFO still accepts a character when the head leaves in the same
  // cycle; a flush discards any character arriving with it.
  assign push    = rx_done & ~flush & (~fifo_full | pop);
  assign ovr_set = rx_done & fifo_full & ~pop & ~flush;

  // Counter advances only below the threshold, so it saturates there and
  // the timeout bit is set exactly once per idle period.
  assign to_inc = baud_tick & ~fifo_empty & (to_cnt < to_thr);
  assign to_set = to_inc & ((to_cnt + TO_W'(1)) == to_thr);

  uart_rx_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk   (PCLK),
    .rst_n (PRESETn),
    .push  (push),
    .pop   (pop),
    .flush (flush),
    .din   (rx_data),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fifo_level)
  );

  always_ff @(posedge PCLK) begin
    if (!PRESETn) begin
      rxen      <= 1'b0;
      data_bits <= DATA_BITS_MAX;
      parity    <= 1'b0;
      stop2     <= 1'b0;
      ie_rx     <= 1'b0;
      ie_err    <= 1'b0;
      watermark <= '0;
      to_thr    <= '0;
      overrun   <= 1'b0;
      frame_err <= 1'b0;
      timeout   <= 1'b0;
      to_cnt    <= '0;
      irq       <= 1'b0;
    end else begin
      if (wr_ctrl) begin
        rxen      <= apb.PWDATA[CTRL_RXEN];
        ie_rx     <= apb.PWDATA[CTRL_IE_RX];
        ie_err    <= apb.PWDATA[CTRL_IE_ERR];
        watermark <= apb.PWDATA[CTRL_WM_HI:CTRL_WM_LO];
        // Frame format is frozen while the receiver is enabled.
        if (!rxen) begin
          data_bits <= clamp_data_bits(apb.PWDATA[CTRL_DBITS_HI:CTRL_DBITS_LO]);
          parity    <= apb.PWDATA[CTRL_PARITY];
          stop2     <= apb.PWDATA[CTRL_STOP2];
        end
      end
      if (wr_to) to_thr <= apb.PWDATA[TO_W-1:0];

      // Sticky bits: a new event in the clearing cycle wins over the W1C.
      overrun   <= ovr_set | (overrun & ~(wr_status & apb.PWDATA[STAT_OVERRUN]));
      frame_err <= error_rx_detect |
                   (frame_err & ~(wr_status & apb.PWDATA[STAT_FRAME_ERR]));
      timeout   <= to_set | (timeout & ~(wr_status & apb.PWDATA[STAT_TIMEOUT]));

      if (push || pop || flush) to_cnt <= '0;
      else if (to_inc)          to_cnt <= to_cnt + TO_W'(1);

      irq <= irq_next;
    end
  end

  // Watermark 0 behaves as 1 so an enabled rx interrupt always means data.
  assign level8 = 8'(fifo_level);
  assign wm_eff = (watermark == 4'd0) ? 4'd1 : watermark;

  always_comb begin
    irq_next = 1'b0;
    if (ie_rx && ((level8 >= {4'b0, wm_eff}) || timeout)) irq_next = 1'b1;
    if (ie_err && (overrun || frame_err)) irq_next = 1'b1;
  end

  always_comb begin
    rdata = '0;
    case (reg_sel)
      REG_CTRL: begin
        rdata[CTRL_RXEN]                   = rxen;
        rdata[CTRL_DBITS_HI:CTRL_DBITS_LO] = data_bits;
        rdata[CTRL_PARITY]                 = parity;
        rdata[CTRL_STOP2]                  = stop2;
        rdata[CTRL_IE_RX]                  = ie_rx;
        rdata[CTRL_IE_ERR]                 = ie_err;
        rdata[CTRL_WM_HI:CTRL_WM_LO]       = watermark;
      end
      REG_STATUS: begin
        rdata[STAT_EMPTY]                    = fifo_empty;
        rdata[STAT_FULL]                     = fifo_full;
        rdata[STAT_OVERRUN]                  = overrun;
        rdata[STAT_FRAME_ERR]                = frame_err;
        rdata[STAT_TIMEOUT]                  = timeout;
        rdata[STAT_LEVEL_HI:STAT_LEVEL_LO]   = 7'(fifo_level);
      end
      REG_DATA: begin
        if (!fifo_empty) rdata[7:0] = fifo_dout;
      end
      REG_TIMEOUT: begin
        rdata[TO_W-1:0] = to_thr;
      end
      default: rdata = '0;
    endcase
  end

  assign apb.PRDATA  = (PRESETn && rd_en) ? rdata : 32'h0;
  assign apb.PREADY  = 1'b1;
  assign apb.PSLVERR = PRESETn & acc & ~addr_ok;

  assign RXen                = rxen;
  assign number_data_receive = data_bits;
  assign parity_bit_mode     = parity;
  assign stop_bit_twice      = stop2;
  assign data_is_avail       = rxen & ~fifo_full;

  assign unused_bits = ^apb.PWDATA[31:16];

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Bench for uart_rx_ctrl: register table vectors plus hand-written
// multi-cycle sequences (FIFO fill/overrun, pop+push while full, timeout,
// watermark/flush, error W1C race, reset mid-frame).
module tb_uart_rx_ctrl;
  import uart_pkg::*;

  logic       PCLK = 1'b0;
  logic       PRESETn;
  logic       baud_tick;
  logic       rx_done;
  logic [7:0] rx_data;
  logic       error_rx_detect;
  logic       RXen;
  logic [3:0] number_data_receive;
  logic       parity_bit_mode;
  logic       stop_bit_twice;
  logic       data_is_avail;
  logic       irq;

  int total = 0;
  int bad   = 0;

  uart_rx_ctrl_if apb ();

  uart_rx_ctrl #(.DEPTH(16), .TO_W(8)) dut (
    .PCLK                (PCLK),
    .PRESETn             (PRESETn),
    .apb                 (apb),
    .baud_tick           (baud_tick),
    .rx_done             (rx_done),
    .rx_data             (rx_data),
    .error_rx_detect     (error_rx_detect),
    .RXen                (RXen),
    .number_data_receive (number_data_receive),
    .parity_bit_mode     (parity_bit_mode),
    .stop_bit_twice      (stop_bit_twice),
    .data_is_avail       (data_is_avail),
    .irq                 (irq)
  );

  // Clock / reset.
  always #5 PCLK = ~PCLK;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    bit          is_wr;
    logic [3:0]  addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    bit          exp_err;
    logic [3:0]  exp_ndr;
    bit          exp_rxen;
    bit          exp_par;
    bit          exp_stop;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic add_vec(input bit wr, input logic [3:0] a, input logic [31:0] d,
                         input logic [31:0] er, input bit ee, input logic [3:0] ndr,
                         input bit rxe, input bit par, input bit stp);
    vec_t v;
    v.is_wr = wr; v.addr = a; v.wdata = d; v.exp_rdata = er; v.exp_err = ee;
    v.exp_ndr = ndr; v.exp_rxen = rxe; v.exp_par = par; v.exp_stop = stp;
    vecs.push_back(v);
  endtask

  // Driver: one APB transfer; optional rx_done / error strobe in the access phase.
  task automatic apb_access(input bit wr, input logic [3:0] a, input logic [31:0] d,
                            input bit rx_stb, input logic [7:0] rx_val, input bit err_stb,
                            output logic [31:0] rd, output logic err);
    @(negedge PCLK);
    apb.PSEL = 1'b1; apb.PENABLE = 1'b0; apb.PWRITE = wr; apb.PADDR = a; apb.PWDATA = d;
    @(negedge PCLK);
    apb.PENABLE = 1'b1;
    if (rx_stb) begin rx_done = 1'b1; rx_data = rx_val; end
    if (err_stb) error_rx_detect = 1'b1;
    #1;
    rd  = apb.PRDATA;
    err = apb.PSLVERR;
    @(negedge PCLK);
    apb.PSEL = 1'b0; apb.PENABLE = 1'b0; apb.PWRITE = 1'b0;
    rx_done = 1'b0; error_rx_detect = 1'b0;
  endtask

  task automatic wr(input logic [3:0] a, input logic [31:0] d);
    logic [31:0] rd; logic err;
    apb_access(1'b1, a, d, 1'b0, 8'h0, 1'b0, rd, err);
  endtask

  task automatic rd_check(input string name, input logic [3:0] a, input logic [31:0] exp);
    logic [31:0] rd; logic err;
    apb_access(1'b0, a, 32'h0, 1'b0, 8'h0, 1'b0, rd, err);
    check(name, rd, exp);
  endtask

  task automatic rx_push(input logic [7:0] v);
    @(negedge PCLK); rx_done = 1'b1; rx_data = v;
    @(negedge PCLK); rx_done = 1'b0;
  endtask

  task automatic tick();
    @(negedge PCLK); baud_tick = 1'b1;
    @(negedge PCLK); baud_tick = 1'b0;
  endtask

  initial begin
    logic [31:0] rd;
    logic        err;

    apb.PSEL = 0; apb.PENABLE = 0; apb.PWRITE = 0; apb.PADDR = 0; apb.PWDATA = 0;
    baud_tick = 0; rx_done = 0; rx_data = 0; error_rx_detect = 0;
    PRESETn = 1'b0;

    // Register table: wr, addr, wdata, exp_rdata, exp_err, ndr, rxen, par, stop.
    add_vec(0, ADDR_CTRL,    0,        32'h10, 0, 8, 0, 0, 0);
    add_vec(0, ADDR_STATUS,  0,        32'h01, 0, 8, 0, 0, 0);
    add_vec(0, ADDR_TIMEOUT, 0,        32'h00, 0, 8, 0, 0, 0);
    add_vec(0, ADDR_DATA,    0,        32'h00, 0, 8, 0, 0, 0);
    add_vec(1, ADDR_CTRL,    32'h0B,   0,      0, 5, 1, 0, 0);
    add_vec(0, ADDR_CTRL,    0,        32'h0B, 0, 5, 1, 0, 0);
    add_vec(1, ADDR_CTRL,    32'h0F,   0,      0, 5, 1, 0, 0);
    add_vec(0, ADDR_CTRL,    0,        32'h0B, 0, 5, 1, 0, 0);
    add_vec(1, ADDR_CTRL,    32'h0E,   0,      0, 5, 0, 0, 0);
    add_vec(0, ADDR_CTRL,    0,        32'h0A, 0, 5, 0, 0, 0);
    add_vec(1, ADDR_CTRL,    32'h0F,   0,      0, 7, 1, 0, 0);
    add_vec(0, ADDR_CTRL,    0,        32'h0F, 0, 7, 1, 0, 0);
    add_vec(1, ADDR_CTRL,    32'h0E,   0,      0, 7, 0, 0, 0);
    add_vec(1, ADDR_CTRL,    32'h02,   0,      0, 5, 0, 0, 0);
    add_vec(0, ADDR_CTRL,    0,        32'h0A, 0, 5, 0, 0, 0);
    add_vec(1, ADDR_CTRL,    32'h1E,   0,      0, 8, 0, 0, 0);
    add_vec(0, ADDR_CTRL,    0,        32'h10, 0, 8, 0, 0, 0);
    add_vec(1, ADDR_CTRL,    32'h70,   0,      0, 8, 0, 1, 1);
    add_vec(0, ADDR_CTRL,    0,        32'h70, 0, 8, 0, 1, 1);
    add_vec(1, 4'h1,         32'hFF,   0,      1, 8, 0, 1, 1);
    add_vec(0, ADDR_CTRL,    0,        32'h70, 0, 8, 0, 1, 1);
    add_vec(0, 4'h5,         0,        32'h00, 1, 8, 0, 1, 1);
    add_vec(1, ADDR_CTRL,    32'h10,   0,      0, 8, 0, 0, 0);
    add_vec(1, ADDR_TIMEOUT, 32'h1A5,  0,      0, 8, 0, 0, 0);
    add_vec(0, ADDR_TIMEOUT, 0,        32'hA5, 0, 8, 0, 0, 0);
    add_vec(1, ADDR_TIMEOUT, 32'h0,    0,      0, 8, 0, 0, 0);
    add_vec(0, ADDR_TIMEOUT, 0,        32'h00, 0, 8, 0, 0, 0);

    // Reset values while reset is held.
    repeat (3) @(negedge PCLK);
    check("rst_rxen", RXen, 0);
    check("rst_ndr", number_data_receive, 8);
    check("rst_irq", irq, 0);
    check("rst_avail", data_is_avail, 0);
    check("rst_prdata", apb.PRDATA, 0);
    check("rst_pslverr", apb.PSLVERR, 0);
    check("pready", apb.PREADY, 1);
    PRESETn = 1'b1;

    // Table-driven register vectors.
    for (int i = 0; i < vecs.size(); i++) begin
      apb_access(vecs[i].is_wr, vecs[i].addr, vecs[i].wdata, 1'b0, 8'h0, 1'b0, rd, err);
      if (!vecs[i].is_wr) check($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rdata);
      check($sformatf("vec%0d_pslverr", i), err, vecs[i].exp_err);
      check($sformatf("vec%0d_ndr", i), number_data_receive, vecs[i].exp_ndr);
      check($sformatf("vec%0d_rxen", i), RXen, vecs[i].exp_rxen);
      check($sformatf("vec%0d_parity", i), parity_bit_mode, vecs[i].exp_par);
      check($sformatf("vec%0d_stop2", i), stop_bit_twice, vecs[i].exp_stop);
    end

    // Fill past full: 17 characters, last one overruns.
    wr(ADDR_CTRL, 32'h11);
    check("fill_avail_before", data_is_avail, 1);
    for (int i = 0; i <= 16; i++) rx_push(8'(i));
    rd_check("fill_status", ADDR_STATUS, 32'h1006);
    check("fill_avail_full", data_is_avail, 0);
    check("fill_irq_off", irq, 0);
    for (int i = 0; i < 16; i++) rd_check($sformatf("fill_data%0d", i), ADDR_DATA, 32'(i));
    rd_check("drain_status", ADDR_STATUS, 32'h05);
    rd_check("empty_read", ADDR_DATA, 32'h0);
    wr(ADDR_STATUS, 32'h04);
    rd_check("ovr_w1c", ADDR_STATUS, 32'h01);

    // Full FIFO: pop and rx_done in the same cycle, no overrun.
    for (int i = 0; i < 16; i++) rx_push(8'h20 + 8'(i));
    rd_check("full2_status", ADDR_STATUS, 32'h1002);
    apb_access(1'b0, ADDR_DATA, 32'h0, 1'b1, 8'h55, 1'b0, rd, err);
    check("popush_data", rd, 32'h20);
    rd_check("popush_status", ADDR_STATUS, 32'h1002);
    for (int i = 1; i < 16; i++) rd_check($sformatf("popush_data%0d", i), ADDR_DATA, 32'h20 + 32'(i));
    rd_check("popush_last", ADDR_DATA, 32'h55);
    rd_check("popush_empty", ADDR_STATUS, 32'h01);

    // Character timeout.
    wr(ADDR_TIMEOUT, 32'h3);
    wr(ADDR_CTRL, 32'hF091);
    rx_push(8'h77);
    tick(); tick();
    rd_check("to_before", ADDR_STATUS, 32'h0100);
    check("to_irq_before", irq, 0);
    tick();
    check("to_irq_latency", irq, 0);
    @(negedge PCLK);
    check("to_irq_set", irq, 1);
    rd_check("to_status", ADDR_STATUS, 32'h0110);
    wr(ADDR_STATUS, 32'h10);
    rd_check("to_w1c", ADDR_STATUS, 32'h0100);
    tick(); tick();
    rd_check("to_saturated", ADDR_STATUS, 32'h0100);
    check("to_irq_clear", irq, 0);
    rd_check("to_pop", ADDR_DATA, 32'h77);
    tick(); tick();
    rd_check("to_after_pop", ADDR_STATUS, 32'h01);

    // Watermark interrupt and flush.
    wr(ADDR_TIMEOUT, 32'h0);
    wr(ADDR_CTRL, 32'h2091);
    rx_push(8'h01);
    @(negedge PCLK);
    check("wm_irq_below", irq, 0);
    rx_push(8'h02);
    @(negedge PCLK);
    check("wm_irq_at", irq, 1);
    wr(ADDR_CTRL, 32'h2291);
    rd_check("flush_ctrl_rb", ADDR_CTRL, 32'h2091);
    rd_check("flush_status", ADDR_STATUS, 32'h01);
    check("flush_irq", irq, 0);
    rx_push(8'h03);
    rd_check("flush2_pre", ADDR_STATUS, 32'h0100);
    apb_access(1'b1, ADDR_CTRL, 32'h2291, 1'b1, 8'h04, 1'b0, rd, err);
    rd_check("flush_push_drop", ADDR_STATUS, 32'h01);
    wr(ADDR_CTRL, 32'h0091);
    rx_push(8'h05);
    @(negedge PCLK);
    check("wm0_irq", irq, 1);
    wr(ADDR_CTRL, 32'h0291);

    // Frame error: set wins over W1C in the same cycle.
    wr(ADDR_CTRL, 32'h0111);
    @(negedge PCLK); error_rx_detect = 1'b1;
    @(negedge PCLK); error_rx_detect = 1'b0;
    rd_check("ferr_set", ADDR_STATUS, 32'h09);
    check("ferr_irq", irq, 1);
    apb_access(1'b1, ADDR_STATUS, 32'h08, 1'b0, 8'h0, 1'b1, rd, err);
    rd_check("ferr_race", ADDR_STATUS, 32'h09);
    wr(ADDR_STATUS, 32'h08);
    rd_check("ferr_w1c", ADDR_STATUS, 32'h01);
    check("ferr_irq_clear", irq, 0);

    // Reset mid-frame with an rx_done on the reset edge.
    rx_push(8'h11);
    rx_push(8'h12);
    @(negedge PCLK); error_rx_detect = 1'b1;
    @(negedge PCLK); error_rx_detect = 1'b0;
    PRESETn = 1'b0; rx_done = 1'b1; rx_data = 8'h99;
    @(negedge PCLK); rx_done = 1'b0;
    check("mrst_rxen", RXen, 0);
    check("mrst_irq", irq, 0);
    check("mrst_avail", data_is_avail, 0);
    check("mrst_ndr", number_data_receive, 8);
    PRESETn = 1'b1;
    rd_check("mrst_status", ADDR_STATUS, 32'h01);
    rd_check("mrst_ctrl", ADDR_CTRL, 32'h10);
    rd_check("mrst_data", ADDR_DATA, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
